// File: rtl/mcdp_pkg.sv
// Shared types for the multi-cycle datapath.
// Phase encoding, ALU opcodes and the latched control bundle.
package mcdp_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } phase_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       reg_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       lui;
        logic       branch;
        logic       br_on_zero;
        logic       br_on_gt;
    } ctrl_t;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// Combinational XLEN-wide ALU shared by every phase.
// Flags come straight from the operands/result.
module alu_param
    import mcdp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            greater
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    logic          lt;

    assign shamt = b[SW-1:0];
    assign lt    = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            default: result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign greater = $signed(a) > $signed(b);

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: PC, IR, register file, ALU and phase FSM.
// Memories sit behind req/ready handshakes and may stall any phase.
module multicycle_datapath
    import mcdp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              AW       = 10,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      alu_control,
    input  logic            reg_write,
    input  logic            alu_src_a,
    input  logic            alu_src_b,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            lui,
    input  logic            branch,
    input  logic            br_on_zero,
    input  logic            br_on_gt,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic [XLEN-1:0] pc,
    output logic [2:0]      phase,
    output logic            retire,
    output logic            zero,
    output logic            greater_than,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    phase_t          state, state_next;
    ctrl_t           ctrl, ctrl_in;
    logic [XLEN-1:0] ir, a_reg, b_reg, imm_reg, alu_out, mdr;
    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] src_a, src_b, alu_res, wb_data;
    logic            alu_zero, alu_gt, taken;
    logic            pc_inc, pc_br, rf_we;

    assign ctrl_in = '{
        alu_control: alu_control, reg_write: reg_write,
        alu_src_a: alu_src_a, alu_src_b: alu_src_b,
        mem_read: mem_read, mem_write: mem_write,
        mem_to_reg: mem_to_reg, lui: lui, branch: branch,
        br_on_zero: br_on_zero, br_on_gt: br_on_gt
    };

    assign src_a = ctrl.alu_src_a ? a_reg : pc;
    assign src_b = ctrl.alu_src_b ? imm_reg : b_reg;

    alu_param #(.XLEN(XLEN)) u_alu (
        .a       (src_a),
        .b       (src_b),
        .op      (ctrl.alu_control),
        .result  (alu_res),
        .zero    (alu_zero),
        .greater (alu_gt)
    );

    // Branch decision uses this cycle's flags, not the registered ones.
    assign taken = (ctrl.br_on_zero && alu_zero) || (ctrl.br_on_gt && alu_gt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        pc_inc     = 1'b0;
        pc_br      = 1'b0;
        rf_we      = 1'b0;
        unique case (state)
            FETCH:  if (imem_ready) state_next = DECODE;
            DECODE: state_next = EXEC;
            EXEC: begin
                if (ctrl.branch) begin
                    retire     = 1'b1;
                    pc_br      = taken;
                    pc_inc     = !taken;
                    state_next = FETCH;
                end else if (ctrl.mem_read || ctrl.mem_write) begin
                    state_next = MEM;
                end else if (ctrl.reg_write || ctrl.lui) begin
                    state_next = WB;
                end else begin
                    retire     = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = FETCH;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    if (ctrl.mem_write) begin
                        retire     = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                retire     = 1'b1;
                pc_inc     = 1'b1;
                rf_we      = ctrl.reg_write || ctrl.lui;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            ir           <= '0;
            ctrl         <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            imm_reg      <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            zero         <= 1'b0;
            greater_than <= 1'b0;
        end else begin
            if (state == FETCH && imem_ready) ir <= imem_rdata;
            if (state == DECODE) begin
                a_reg   <= rf[ir[19:15]];
                b_reg   <= rf[ir[24:20]];
                imm_reg <= imm;
                ctrl    <= ctrl_in;
            end
            if (state == EXEC) begin
                alu_out      <= alu_res;
                zero         <= alu_zero;
                greater_than <= alu_gt;
            end
            if (state == MEM && dmem_ready && !ctrl.mem_write) mdr <= dmem_rdata;
            if (pc_br)       pc <= imm_reg;
            else if (pc_inc) pc <= pc + 1'b1;
        end
    end

    assign wb_data = ctrl.lui ? imm_reg : (ctrl.mem_to_reg ? mdr : alu_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && ir[11:7] != 5'd0) begin
            rf[ir[11:7]] <= wb_data;
        end
    end

    assign instr      = ir;
    assign phase      = state;
    assign imem_req   = (state == FETCH) && !rst;
    assign imem_addr  = pc[AW-1:0];
    assign dmem_req   = (state == MEM) && !rst;
    assign dmem_we    = dmem_req && ctrl.mem_write;
    assign dmem_addr  = alu_out[AW-1:0];
    assign dmem_wdata = b_reg;
    assign dbg_data   = rf[dbg_addr];

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the single-cycle CPU datapath. An internal phase FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, so one ALU and one memory port per side are reused across phases. Instruction and data memories sit behind valid/ready handshakes, so variable-latency memories can stall the core. Decode and control stay external; the block holds PC, IR, the register file, the ALU and the pipeline-phase registers.

## Interface
- XLEN, 32, datapath and register width (≥8)
- AW, 10, word-address width of both memories (PC is word-addressed, increments by 1)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  out  XLEN  IR contents (feeds external decoder/imm generator)
- imm  in  XLEN  sign-extended immediate from external generator
- alu_control  in  3  ALU op, encoding in package
- reg_write, alu_src_a, alu_src_b, mem_read, mem_write, mem_to_reg, lui, branch  in  1 each  control (alu_src_a: 0=PC, 1=rs1; alu_src_b: 0=rs2, 1=imm)
- br_on_zero, br_on_gt  in  1 each  branch condition enables
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address
- imem_rdata  in  XLEN  fetched word
- imem_ready  in  1  fetch complete
- dmem_req, dmem_we  out  1 each  data request / write
- dmem_addr  out  AW  ALUOut[AW-1:0]
- dmem_wdata  out  XLEN  latched rs2
- dmem_rdata  in  XLEN  load data
- dmem_ready  in  1  data access complete
- pc  out  XLEN  current PC
- phase  out  3  FSM state
- retire  out  1  one-cycle pulse when an instruction completes
- zero, greater_than  out  1 each  registered ALU flags
- dbg_addr  in  5  register-file debug read index
- dbg_data  out  XLEN  combinational read of register dbg_addr

## Operation
- Register file: 32×XLEN; A1=IR[19:15], A2=IR[24:20], A3=IR[11:7]; x0 reads 0, writes ignored.
- FETCH: imem_req=1, imem_addr=pc[AW-1:0]; stays until imem_ready=1, then IR←imem_rdata, go DECODE.
- DECODE: A←rs1, B←rs2, IMM←imm, all control inputs latched into a control register (inputs ignored in later phases). Go EXEC.
- EXEC: ALUOut←ALU(SrcA,SrcB); zero←(result==0); greater_than←signed(SrcA)>signed(SrcB). Next:
  - branch=1: taken = (br_on_zero&&zero_next)||(br_on_gt&&gt_next) using this cycle's ALU flags; pc←taken?IMM:pc+1; retire; go FETCH.
  - mem_read|mem_write: go MEM.
  - reg_write|lui: go WB.
  - else pc←pc+1, retire, go FETCH.
- MEM: dmem_req=1, dmem_we=mem_write, held stable until dmem_ready=1. Store: pc←pc+1, retire, FETCH. Load: MDR←dmem_rdata, go WB.
- WB: rd←lui?IMM:(mem_to_reg?MDR:ALUOut) if reg_write|lui; pc←pc+1; retire; FETCH.
- ALU ops (all XLEN, wrap modulo 2^XLEN): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SLL, 111 SRL (shift amount = B[$clog2(XLEN)-1:0]).
- mem_read and mem_write both set: treated as store.

## Timing
- Reset values: pc=RESET_PC, IR=0, phase=FETCH, retire=0, zero=0, greater_than=0, all req=0, A/B/IMM/ALUOut/MDR=0, register file all 0.
- Zero-wait memories: ALU op 4 cycles, load 5, store 4, branch 3, nop 3 (FETCH→FETCH).
- Each wait cycle of a ready-low memory adds one cycle; req/addr/wdata constant while waiting.
- imem_ready/dmem_ready ignored outside their phase.
- retire asserts in the cycle the FSM leaves its final phase; pc shows new value the next cycle.
- rst mid-instruction: all outputs to reset values immediately (async); pending requests dropped, no register write.
- Branch to IMM wraps to AW bits on imem_addr; pc+1 wraps modulo 2^XLEN.

## Structure
- Package mcdp_pkg: phase enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4), ALU op localparams, control-register struct.
- One sub-module: alu_param (#(XLEN)), combinational, outputs result, zero, greater. Register file and FSM inline.

## Test plan
- Zero-wait imem: ADD x3←x1+x2 with x1=5, x2=7 -> dbg_data(x3)=12, retire after exactly 4 cycles.
- imem_ready low 3 cycles during FETCH -> imem_addr stable, instruction retires at cycle 7.
- Store x2=0xDEAD to addr 4, then load into x5 with dmem_ready 2-cycle delay -> dmem_we=1 once, x5=0xDEAD, load takes 7 cycles.
- Branch SUB 3-3 with br_on_zero=1, imm=0x20 -> pc=0x20, zero=1; with 3-4 -> pc=old+1.
- Write to x0 with 0xFFFF, lui into x7 imm=0x12345000 -> x0 reads 0, x7=0x12345000.
- Assert rst during MEM with dmem_req high -> dmem_req=0, pc=RESET_PC, phase=FETCH same cycle; no register changed.
